// File: rtl/fetch_prefetch_unit_if.sv
// Fetch front-end bus: instruction-memory req/ack port, decode control and the
// instruction stream handed to the IF/ID register.
interface fetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4_out;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues req/ack word fetches and
// queues {instruction, PC+4} pairs for decode; redirects flush and drop stale data.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_unit_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {sFetch, sDrop} fetchState_e;

  fetchState_e    state;
  logic [31:0]    fetchPc;
  logic [31:0]    dropAddr;
  logic           reqPending;
  logic [CW-1:0]  count;
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic [31:0]    instMem [DEPTH];
  logic [31:0]    pcMem   [DEPTH];

  logic           full;
  logic           push;
  logic           pop;
  logic [31:0]    pcNext;
  logic [31:0]    redirectTarget;

  assign full           = (count == FULL);
  assign pcNext         = fetchPc + 32'd4;
  assign redirectTarget = {bus.redirect_pc[31:2], 2'b00};

  // A pending request must be held through a redirect; gating with rst abandons it on reset.
  assign bus.imem_req  = rst && ((state == sDrop) || reqPending || (!full && !bus.redirect));
  assign bus.imem_addr = (state == sDrop) ? dropAddr : fetchPc;

  assign push = bus.imem_req && bus.imem_ack && (state == sFetch) && !bus.redirect;
  assign pop  = (count != '0) && !bus.stall && !bus.redirect;

  assign bus.inst_valid   = (count != '0);
  assign bus.inst_out     = instMem[rdPtr];
  assign bus.pc_plus4_out = pcMem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= sFetch;
      fetchPc    <= RESET_PC;
      dropAddr   <= '0;
      reqPending <= 1'b0;
      count      <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
    end else begin
      case (state)
        sFetch: begin
          // Redirect while the memory has not yet acked: keep the old request alive
          if (bus.redirect && bus.imem_req && !bus.imem_ack) begin
            state    <= sDrop;
            dropAddr <= fetchPc;
          end
        end
        sDrop: begin
          if (bus.imem_ack) begin
            state <= sFetch;
          end
        end
        default: state <= sFetch;
      endcase

      reqPending <= (state == sFetch) && bus.imem_req && !bus.imem_ack && !bus.redirect;

      if (bus.redirect) begin
        fetchPc <= redirectTarget;
      end else if (push) begin
        fetchPc <= pcNext;
      end

      if (bus.redirect) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (push) begin
          wrPtr <= wrPtr + 1'b1;
        end
        if (pop) begin
          rdPtr <= rdPtr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage, one register pair per entry
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
    logic [31:0] instReg;
    logic [31:0] pcReg;
    logic        wrEn;

    assign wrEn = push && (wrPtr == PW'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        instReg <= '0;
        pcReg   <= '0;
      end else if (wrEn) begin
        instReg <= bus.imem_rdata;
        pcReg   <= pcNext;
      end
    end

    assign instMem[gi] = instReg;
    assign pcMem[gi]   = pcReg;
  end

endmodule
